// File: rtl/jtpopeye_dma_pkg.sv
// Shared constants and state encoding for the Popeye object DMA sequencer.
package jtpopeye_dma_pkg;

    localparam int unsigned DMA_AW  = 10;
    localparam int unsigned DMA_LEN = 1024;

    // Page select bit prepended to AD_DMA by the RAM address mux.
    localparam logic RAM_PAGE_SEL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } dma_state_e;

endpackage

// File: rtl/jtpopeye_dma_ctrl.sv
// Once-per-frame object DMA: grabs the Z80 bus on VB rise, copies LEN bytes of
// the top RAM page into the object line buffer, then releases the bus.
module jtpopeye_dma_ctrl
    import jtpopeye_dma_pkg::*;
#(
    parameter int unsigned AW  = DMA_AW,
    parameter int unsigned LEN = DMA_LEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          VB,
    output logic          busrq_n,
    input  logic          busak_n,
    output logic          dma_cs,
    output logic [AW-1:0] AD_DMA,
    input  logic [7:0]    DD_DMA,
    output logic          obj_we,
    output logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_din,
    output logic          busy,
    output logic          done,
    output logic          miss
);

    // Pointers carry one extra bit so LEN = 2^AW compares without wrapping.
    localparam int unsigned PW    = AW + 1;
    localparam logic [PW-1:0] LEN_P = PW'(LEN);
    localparam logic [PW-1:0] ONE_P = PW'(1);

    dma_state_e    state_q,    state_d;
    logic          vb_l_q,     vb_l_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic          rd_vld_q,   rd_vld_d;
    logic          busrq_n_q,  busrq_n_d;
    logic          dma_cs_q,   dma_cs_d;
    logic [AW-1:0] ad_q,       ad_d;
    logic          obj_we_q,   obj_we_d;
    logic [AW-1:0] obj_addr_q, obj_addr_d;
    logic [7:0]    obj_din_q,  obj_din_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          miss_q,     miss_d;
    logic          trig_c;

    assign trig_c = VB & ~vb_l_q;

    // Next-state and output logic; everything holds unless cen is high.
    always_comb begin
        state_d    = state_q;
        vb_l_d     = vb_l_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_vld_d   = rd_vld_q;
        busrq_n_d  = busrq_n_q;
        dma_cs_d   = dma_cs_q;
        ad_d       = ad_q;
        obj_we_d   = obj_we_q;
        obj_addr_d = obj_addr_q;
        obj_din_d  = obj_din_q;
        busy_d     = busy_q;
        done_d     = done_q;
        miss_d     = miss_q;

        if (cen) begin
            vb_l_d   = VB;
            obj_we_d = 1'b0;
            done_d   = 1'b0;

            if (trig_c && busy_q) begin
                miss_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (trig_c) begin
                        busrq_n_d = 1'b0;
                        busy_d    = 1'b1;
                        rd_ptr_d  = '0;
                        wr_ptr_d  = '0;
                        rd_vld_d  = 1'b0;
                        state_d   = ST_REQ;
                    end
                end

                ST_REQ: begin
                    busrq_n_d = 1'b0;
                    dma_cs_d  = 1'b0;
                    if (!busak_n) begin
                        dma_cs_d = 1'b1;
                        ad_d     = rd_ptr_q[AW-1:0];
                        rd_ptr_d = rd_ptr_q + ONE_P;
                        rd_vld_d = 1'b1;
                        state_d  = ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (busak_n) begin
                        // CPU took the bus back: drop the in-flight byte and
                        // rewind reads to the first byte not yet written.
                        dma_cs_d = 1'b0;
                        rd_vld_d = 1'b0;
                        rd_ptr_d = wr_ptr_q;
                        state_d  = ST_REQ;
                    end else begin
                        if (rd_vld_q) begin
                            obj_we_d   = 1'b1;
                            obj_addr_d = wr_ptr_q[AW-1:0];
                            obj_din_d  = DD_DMA;
                            wr_ptr_d   = wr_ptr_q + ONE_P;
                        end
                        if (rd_ptr_q < LEN_P) begin
                            ad_d     = rd_ptr_q[AW-1:0];
                            rd_ptr_d = rd_ptr_q + ONE_P;
                            rd_vld_d = 1'b1;
                        end else begin
                            rd_vld_d = 1'b0;
                            dma_cs_d = 1'b0;
                            state_d  = ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    // The last byte was written on the XFER exit cycle with
                    // dma_cs already low, so the bus can be handed back here.
                    busrq_n_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset that ignores cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vb_l_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            busrq_n_q  <= 1'b1;
            dma_cs_q   <= 1'b0;
            ad_q       <= '0;
            obj_we_q   <= 1'b0;
            obj_addr_q <= '0;
            obj_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vb_l_q     <= vb_l_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_vld_q   <= rd_vld_d;
            busrq_n_q  <= busrq_n_d;
            dma_cs_q   <= dma_cs_d;
            ad_q       <= ad_d;
            obj_we_q   <= obj_we_d;
            obj_addr_q <= obj_addr_d;
            obj_din_q  <= obj_din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            miss_q     <= miss_d;
        end
    end

    assign busrq_n  = busrq_n_q;
    assign dma_cs   = dma_cs_q;
    assign AD_DMA   = ad_q;
    assign obj_we   = obj_we_q;
    assign obj_addr = obj_addr_q;
    assign obj_din  = obj_din_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign miss     = miss_q;

endmodule
